event_prio_encoder: RTL and testbench

//  Parametrised, registered N-to-log2(N) event encoder with pending-request capture.

---
 rtl/event_prio_encoder_pkg.sv | 27 ++
 rtl/event_prio_encoder_pick.sv | 32 +++
 rtl/event_prio_encoder.sv | 139 +++++++++++++
 tb/tb_event_prio_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/event_prio_encoder_pkg.sv
// Shared types and helpers for the event priority encoder.
package encoder_pkg;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = $clog2(MAX_N);

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } prio_mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } enc_state_e;

    // One-hot vector with bit idx set; zero when idx is outside 0..n-1.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_N) begin
            v[MAX_W'(idx)] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/event_prio_encoder_pick.sv
// Combinational rotating-priority pick: first set bit of req scanning from base upward.
module prio_pick #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    // Scan N positions starting at base, wrapping past N-1 back to 0.
    always_comb begin
        int unsigned k;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(base) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[W'(k)]) begin
                idx = W'(k);
                any = 1'b1;
            end
        end
        multi = |(req & (req - N'(1)));
    end

endmodule

// File: rtl/event_prio_encoder.sv
// Event funnel: captures event pulses into a pending register and grants them one
// at a time on a valid/ready output, fixed or round-robin priority.
module event_prio_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = $clog2(N),
    parameter prio_mode_e  MODE = PRIO_FIXED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] ev_i,
    input  logic [N-1:0] mask_i,
    input  logic         clr_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_multi,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    enc_state_e   state_q, state_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic         multi_q, multi_d;
    logic [N-1:0] pending_q, pending_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         hs;
    logic [N-1:0] cur_oh, served, presented, elig;
    logic [W-1:0] ptr_eff, base;
    logic [W-1:0] pick_idx;
    logic         pick_any, pick_multi;

    // Handshake, eligible set and priority base for this cycle.
    always_comb begin
        hs        = valid_q && out_ready && !clr_i;
        cur_oh    = N'(onehot(32'(idx_q), N));
        served    = hs ? cur_oh : '0;
        presented = valid_q ? cur_oh : '0;
        elig      = pending_q & mask_i & ~presented;
        // A grant completing this cycle moves the RR origin past it immediately.
        ptr_eff   = hs ? idx_q : ptr_q;
        if (MODE == PRIO_RR) begin
            base = (ptr_eff == W'(N - 1)) ? '0 : W'(ptr_eff + W'(1));
        end else begin
            base = '0;
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (elig),
        .base  (base),
        .idx   (pick_idx),
        .any   (pick_any),
        .multi (pick_multi)
    );

    // Next-state: pending capture, overflow, pointer and output FSM.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        multi_d   = multi_q;
        pending_d = (pending_q & ~served) | ev_i;
        ovf_d     = ovf_q | (|(ev_i & pending_q & ~served));
        ptr_d     = hs ? idx_q : ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_PRESENT;
                    valid_d = 1'b1;
                    idx_d   = pick_idx;
                    multi_d = pick_multi;
                end
            end
            ST_PRESENT: begin
                if (hs) begin
                    if (pick_any) begin
                        idx_d   = pick_idx;
                        multi_d = pick_multi;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Flush wins over any same-cycle event or handshake.
        if (clr_i) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            idx_d     = '0;
            multi_d   = 1'b0;
            pending_d = '0;
            ovf_d     = 1'b0;
            ptr_d     = W'(N - 1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            multi_q   <= 1'b0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= W'(N - 1);
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            multi_q   <= multi_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_multi  = multi_q;
    assign pending_o  = pending_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_event_prio_encoder.sv
// Directed bench: fixed-priority and round-robin instances share one stimulus.
module tb_event_prio_encoder;
    import encoder_pkg::*;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] ev_i;
    logic [N-1:0] mask_i;
    logic         clr_i;
    logic         out_ready;

    logic         fx_valid, rr_valid;
    logic [W-1:0] fx_idx, rr_idx;
    logic         fx_multi, rr_multi;
    logic [N-1:0] fx_pend, rr_pend;
    logic         fx_ovf, rr_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    event_prio_encoder #(.N(N), .MODE(PRIO_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .ev_i(ev_i), .mask_i(mask_i), .clr_i(clr_i),
        .out_valid(fx_valid), .out_ready(out_ready), .out_idx(fx_idx),
        .out_multi(fx_multi), .pending_o(fx_pend), .overflow_o(fx_ovf)
    );

    event_prio_encoder #(.N(N), .MODE(PRIO_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ev_i(ev_i), .mask_i(mask_i), .clr_i(clr_i),
        .out_valid(rr_valid), .out_ready(out_ready), .out_idx(rr_idx),
        .out_multi(rr_multi), .pending_o(rr_pend), .overflow_o(rr_ovf)
    );

    typedef struct {
        logic [7:0] ev;
        logic [7:0] mask;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] idx;
        logic       m;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    int exp_fx  [6] = '{0, 1, 0, 1, 0, 1};
    int exp_rr  [6] = '{0, 1, 2, 0, 1, 2};
    int exp_alt [4] = '{0, 7, 0, 7};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ev, input logic [7:0] mask, input logic rdy, input logic clr);
        ev_i      = ev;
        mask_i    = mask;
        out_ready = rdy;
        clr_i     = clr;
    endtask

    initial begin
        //          ev     mask   rdy   clr   v     idx   m     pend   ovf
        tbl[0]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h24, 1'b0};
        tbl[1]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h24, 1'b0};
        tbl[2]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 1'b0};
        tbl[3]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0};
        tbl[6]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 1'b0};
        tbl[7]  = '{8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h05, 1'b0};
        tbl[8]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h05, 1'b0};
        tbl[9]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 1'b0};
        tbl[10] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{8'h30, 8'h0F, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h30, 1'b0};
        tbl[12] = '{8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h30, 1'b0};
        tbl[13] = '{8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h30, 1'b0};
        tbl[14] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 8'h30, 1'b0};
        tbl[15] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 1'b0};
        tbl[16] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0};
        tbl[18] = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b1};
        tbl[19] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b1};
        tbl[20] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[21] = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0};
        tbl[22] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b0};
        tbl[23] = '{8'h08, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0};
        tbl[24] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b0};
        tbl[25] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[26] = '{8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h02, 1'b0};
        tbl[27] = '{8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h03, 1'b0};
        tbl[28] = '{8'h02, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h03, 1'b1};
        tbl[29] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[30] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};

        // Reset state of both instances.
        rst_n = 1'b0;
        drive(8'h00, 8'hFF, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst fx valid", 64'(fx_valid), 64'(0));
        chk("rst fx idx",   64'(fx_idx),   64'(0));
        chk("rst fx multi", 64'(fx_multi), 64'(0));
        chk("rst fx pend",  64'(fx_pend),  64'(0));
        chk("rst fx ovf",   64'(fx_ovf),   64'(0));
        chk("rst rr valid", 64'(rr_valid), 64'(0));
        chk("rst rr pend",  64'(rr_pend),  64'(0));
        rst_n = 1'b1;
        step();

        // Table: fixed-priority instance, one edge per row.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].ev, tbl[i].mask, tbl[i].rdy, tbl[i].clr);
            step();
            chk($sformatf("row%0d valid", i), 64'(fx_valid), 64'(tbl[i].v));
            chk($sformatf("row%0d pend", i),  64'(fx_pend),  64'(tbl[i].pend));
            chk($sformatf("row%0d ovf", i),   64'(fx_ovf),   64'(tbl[i].ovf));
            if (tbl[i].v || tbl[i].clr) begin
                chk($sformatf("row%0d idx", i),   64'(fx_idx),   64'(tbl[i].idx));
                chk($sformatf("row%0d multi", i), 64'(fx_multi), 64'(tbl[i].m));
            end
        end

        // Fixed vs RR: pending 0x07 re-pulsed every cycle, ready held high.
        drive(8'h00, 8'hFF, 1'b0, 1'b1);
        step();
        drive(8'h07, 8'hFF, 1'b1, 1'b0);
        step();
        chk("pri07 fx pend", 64'(fx_pend), 64'h07);
        chk("pri07 rr pend", 64'(rr_pend), 64'h07);
        for (int j = 0; j < 6; j++) begin
            ev_i = (j == 0) ? 8'h00 : 8'h07;
            step();
            chk($sformatf("pri07 g%0d fx valid", j), 64'(fx_valid), 64'(1));
            chk($sformatf("pri07 g%0d rr valid", j), 64'(rr_valid), 64'(1));
            chk($sformatf("pri07 g%0d fx idx", j),   64'(fx_idx),   64'(exp_fx[j]));
            chk($sformatf("pri07 g%0d rr idx", j),   64'(rr_idx),   64'(exp_rr[j]));
        end
        chk("pri07 rr ovf", 64'(rr_ovf), 64'(1));

        // RR: pending 0x81 re-pulsed; pointer restarts at bit 0 after a flush.
        drive(8'h00, 8'hFF, 1'b0, 1'b1);
        step();
        chk("clr rr ovf", 64'(rr_ovf), 64'(0));
        drive(8'h81, 8'hFF, 1'b1, 1'b0);
        step();
        for (int j = 0; j < 4; j++) begin
            ev_i = (j == 0) ? 8'h00 : 8'h81;
            step();
            chk($sformatf("rr81 g%0d valid", j), 64'(rr_valid), 64'(1));
            chk($sformatf("rr81 g%0d idx", j),   64'(rr_idx),   64'(exp_alt[j]));
        end

        // Async reset while an index is presented and ready is high.
        drive(8'h00, 8'hFF, 1'b0, 1'b1);
        step();
        drive(8'h04, 8'hFF, 1'b0, 1'b0);
        step();
        ev_i = 8'h00;
        step();
        chk("arst pre valid", 64'(fx_valid), 64'(1));
        chk("arst pre idx",   64'(fx_idx),   64'(2));
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(fx_valid), 64'(0));
        chk("arst pend",  64'(fx_pend),  64'(0));
        chk("arst rr valid", 64'(rr_valid), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("arst post valid", 64'(fx_valid), 64'(0));
        chk("arst post pend",  64'(fx_pend),  64'(0));
        chk("arst post ovf",   64'(fx_ovf),   64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
